clk_out_gen_multi: RTL

//  Parametrised multi-channel clock-forwarding generator: derives NUM_CH divided

---
 rtl/clk_out_gen_pkg.sv | 16 +
 rtl/clk_out_ch.sv | 108 ++++++++++
 rtl/clk_out_gen_multi.sv | 128 ++++++++++++
 3 files changed

// File: rtl/clk_out_gen_pkg.sv
// Shared types and constants for the multi-channel clock-forwarding generator.
//   state_t  : lock FSM states
//   MIN_DIV  : smallest legal divide ratio
//   LOSS_W   : width of the saturating lock-loss counter
package clk_out_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned LOSS_W  = 8;

endpackage

// File: rtl/clk_out_ch.sv
// One divided-clock channel: active/shadow config, pending flag, period
// counter and registered clock output.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   active                FSM in RUN with lock present
//   start                 first active cycle after (re)entering RUN
//   sync                  realign request (already qualified with active)
//   wr_act, wr_shadow     config write strobes (direct / deferred)
//   wdiv, wphase, wen     config write data
//   clk_out               registered divided clock
//   pend                  shadow config waiting for a period boundary
module clk_out_ch
    import clk_out_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             start,
    input  logic             sync,
    input  logic             wr_act,
    input  logic             wr_shadow,
    input  logic [DIV_W-1:0] wdiv,
    input  logic [DIV_W-1:0] wphase,
    input  logic             wen,
    output logic             clk_out,
    output logic             pend
);

    logic [DIV_W-1:0] div_act, phase_act, div_sh, phase_sh, cnt;
    logic             en_act, en_sh;

    logic [DIV_W-1:0] div_eff, phase_eff, high_eff, high_act, load, cnt_wrap;
    logic             en_eff, apply;

    // Effective config: a pending shadow takes over whenever config is applied
    always_comb begin
        div_eff   = pend ? div_sh   : div_act;
        phase_eff = pend ? phase_sh : phase_act;
        en_eff    = pend ? en_sh    : en_act;
        high_eff  = div_eff - (div_eff >> 1);
        high_act  = div_act - (div_act >> 1);
        load      = (phase_eff >= div_eff) ? '0 : phase_eff;
        cnt_wrap  = (cnt == div_act - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        // Last cycle of a period is always low, so switching here cannot glitch
        apply     = start || (pend && ((cnt == div_act - DIV_W'(1)) || !en_act));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_act   <= DIV_W'(DEF_DIV);
            phase_act <= '0;
            en_act    <= 1'b0;
            div_sh    <= DIV_W'(DEF_DIV);
            phase_sh  <= '0;
            en_sh     <= 1'b0;
            pend      <= 1'b0;
            cnt       <= '0;
            clk_out   <= 1'b0;
        end else if (!active) begin
            // Outside RUN: outputs parked low, writes go straight to act
            cnt     <= '0;
            clk_out <= 1'b0;
            pend    <= 1'b0;
            if (wr_act) begin
                div_act   <= wdiv;
                phase_act <= wphase;
                en_act    <= wen;
            end else if (pend) begin
                div_act   <= div_sh;
                phase_act <= phase_sh;
                en_act    <= en_sh;
            end
        end else begin
            if (sync) begin
                div_act   <= div_eff;
                phase_act <= phase_eff;
                en_act    <= en_eff;
                pend      <= 1'b0;
                cnt       <= en_eff ? load : '0;
                clk_out   <= en_eff && (load < high_eff);
            end else if (apply) begin
                div_act   <= div_eff;
                phase_act <= phase_eff;
                en_act    <= en_eff;
                pend      <= 1'b0;
                cnt       <= '0;
                clk_out   <= en_eff;
            end else if (en_act) begin
                cnt     <= cnt_wrap;
                clk_out <= (cnt_wrap < high_act);
            end else begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end
            // Only possible while pend is low, so it never races an apply
            if (wr_shadow) begin
                div_sh   <= wdiv;
                phase_sh <= wphase;
                en_sh    <= wen;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_out_gen_multi.sv
// Multi-channel clock-forwarding generator: NUM_CH divided clocks from the
// PLL output, gated on a debounced lock, with glitch-free config updates.
// Ports:
//   sys_clk, rst_n        PLL output clock, synchronous active-low reset
//   pll_locked            asynchronous PLL lock (synchronised here)
//   cfg_valid/cfg_ready   config handshake (cfg_ready is combinational)
//   cfg_ch/div/phase/en   config payload
//   sync_start            realign all enabled channels (RUN only)
//   clk_out               registered divided clocks
//   running               FSM in RUN
//   cfg_err               one-cycle pulse on a rejected config
//   lock_loss_cnt         saturating count of lock losses in RUN
module clk_out_gen_multi
    import clk_out_gen_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DEF_DIV   = 8,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    input  logic              sync_start,
    output logic [NUM_CH-1:0] clk_out,
    output logic              running,
    output logic              cfg_err,
    output logic [LOSS_W-1:0] lock_loss_cnt
);

    localparam int unsigned WAIT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);

    state_t             state;
    logic               lk_meta, lk, run_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [NUM_CH-1:0]  sel, pend;
    logic               active, start, sync, ch_ok, div_ok, xfer, good;

    // Channel decode and handshake
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (cfg_ch == 4'(i));
        end
        ch_ok     = |sel;
        div_ok    = (cfg_div >= DIV_W'(MIN_DIV));
        cfg_ready = ~|(sel & pend);
        xfer      = cfg_valid && cfg_ready;
        good      = xfer && ch_ok && div_ok;
        active    = (state == RUN) && lk;
        start     = active && !run_q;
        sync      = sync_start && active;
    end

    // Lock synchroniser, lock FSM, error pulse and loss counter
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            lk_meta       <= 1'b0;
            lk            <= 1'b0;
            run_q         <= 1'b0;
            state         <= WAIT_LOCK;
            wait_cnt      <= '0;
            running       <= 1'b0;
            cfg_err       <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
            run_q   <= active;
            cfg_err <= xfer && !(ch_ok && div_ok);
            case (state)
                WAIT_LOCK: begin
                    wait_cnt <= '0;
                    if (lk) state <= SETTLE;
                end
                SETTLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state   <= WAIT_LOCK;
                        running <= 1'b0;
                        if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    running <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_out_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk       (sys_clk),
            .rst_n     (rst_n),
            .active    (active),
            .start     (start),
            .sync      (sync),
            .wr_act    (good && sel[g] && !active),
            .wr_shadow (good && sel[g] && active),
            .wdiv      (cfg_div),
            .wphase    (cfg_phase),
            .wen       (cfg_en),
            .clk_out   (clk_out[g]),
            .pend      (pend[g])
        );
    end

endmodule
